// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two buffered producers share one registered write port, round-robin.
// Optional scoreboard output Busy_Vec is built when RF_SCBD_EN is defined.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            Flush,
  input  logic            A_Valid,
  output logic            A_Ready,
  input  logic [4:0]      A_Rd,
  input  logic [XLEN-1:0] A_Data,
  input  logic            B_Valid,
  output logic            B_Ready,
  input  logic [4:0]      B_Rd,
  input  logic [XLEN-1:0] B_Data,
  output logic            Reg_Wr,
  output logic [4:0]      Rd_Wr,
  output logic [XLEN-1:0] Rd_In,
`ifdef RF_SCBD_EN
  output logic [31:0]     Busy_Vec,
`endif
  output logic            Idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a source transfers on a rising edge where X_Valid && X_Ready;
  // X_Ready depends only on FIFO fullness and Flush, never on X_Valid.
  logic [1:0]      in_valid;
  logic [4:0]      in_rd   [2];
  logic [XLEN-1:0] in_data [2];

  assign in_valid   = {B_Valid, A_Valid};
  assign in_rd[0]   = A_Rd;
  assign in_rd[1]   = B_Rd;
  assign in_data[0] = A_Data;
  assign in_data[1] = B_Data;

  logic [PW-1:0]   wp_q [2];
  logic [PW-1:0]   wp_d [2];
  logic [PW-1:0]   rp_q [2];
  logic [PW-1:0]   rp_d [2];
  logic [CW-1:0]   cnt_q [2];
  logic [CW-1:0]   cnt_d [2];
  logic [4:0]      rd_mem_q   [2][DEPTH];
  logic [4:0]      rd_mem_d   [2][DEPTH];
  logic [XLEN-1:0] data_mem_q [2][DEPTH];
  logic [XLEN-1:0] data_mem_d [2][DEPTH];

  logic            rr_q, rr_d;
  logic            reg_wr_q, reg_wr_d;
  logic [4:0]      rd_wr_q, rd_wr_d;
  logic [XLEN-1:0] rd_in_q, rd_in_d;

  logic [1:0] full, not_empty, ready, push, pop;
  logic       any_ne;
  logic       sel;

  always_comb begin
    full      = '0;
    not_empty = '0;
    ready     = '0;
    push      = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]      = (cnt_q[s] == CW'(DEPTH));
      not_empty[s] = (cnt_q[s] != '0);
      ready[s]     = !full[s] && !Flush;
      // Rd==0 completes the handshake but is discarded.
      push[s]      = in_valid[s] && ready[s] && (in_rd[s] != 5'd0);
    end
  end

  // rr_q=0 favours A, rr_q=1 favours B; only consulted when both hold entries.
  always_comb begin
    any_ne = |not_empty;
    sel    = (&not_empty) ? rr_q : not_empty[1];
    pop    = '0;
    if (any_ne && !Flush) pop[sel] = 1'b1;
  end

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    rr_d       = rr_q;
    reg_wr_d   = 1'b0;
    rd_wr_d    = rd_wr_q;
    rd_in_d    = rd_in_q;
    if (Flush) begin
      for (int s = 0; s < 2; s++) begin
        wp_d[s]  = '0;
        rp_d[s]  = '0;
        cnt_d[s] = '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          rd_mem_d[s][wp_q[s]]   = in_rd[s];
          data_mem_d[s][wp_q[s]] = in_data[s];
          wp_d[s]                = wp_q[s] + PW'(1);
        end
        if (pop[s]) rp_d[s] = rp_q[s] + PW'(1);
        cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
      if (any_ne) begin
        reg_wr_d = 1'b1;
        rd_wr_d  = rd_mem_q[sel][rp_q[sel]];
        rd_in_d  = data_mem_q[sel][rp_q[sel]];
        rr_d     = ~sel;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      rr_q     <= 1'b0;
      reg_wr_q <= 1'b0;
      rd_wr_q  <= '0;
      rd_in_q  <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      reg_wr_q <= reg_wr_d;
      rd_wr_q  <= rd_wr_d;
      rd_in_q  <= rd_in_d;
    end
  end

  // Storage needs no reset: only entries inside the occupancy window are ever read.
  always_ff @(posedge CLK) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign A_Ready = ready[0];
  assign B_Ready = ready[1];
  assign Reg_Wr  = reg_wr_q;
  assign Rd_Wr   = rd_wr_q;
  assign Rd_In   = rd_in_q;
  assign Idle    = !any_ne && !reg_wr_q;

`ifdef RF_SCBD_EN
  always_comb begin
    Busy_Vec = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < cnt_q[s]) Busy_Vec[rd_mem_q[s][rp_q[s] + PW'(k)]] = 1'b1;
      end
    end
    if (reg_wr_q) Busy_Vec[rd_wr_q] = 1'b1;
    Busy_Vec[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table vectors, hand sequences and random traffic,
// all writes checked against per-source expected queues.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            rst, Flush;
  logic            A_Valid, A_Ready, B_Valid, B_Ready;
  logic [4:0]      A_Rd, B_Rd, Rd_Wr;
  logic [XLEN-1:0] A_Data, B_Data, Rd_In;
  logic            Reg_Wr, Idle;
`ifdef RF_SCBD_EN
  logic [31:0]     Busy_Vec;
`endif

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .rst(rst), .Flush(Flush),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Rd(A_Rd), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Rd(B_Rd), .B_Data(B_Data),
    .Reg_Wr(Reg_Wr), .Rd_Wr(Rd_Wr), .Rd_In(Rd_In),
`ifdef RF_SCBD_EN
    .Busy_Vec(Busy_Vec),
`endif
    .Idle(Idle)
  );

  logic [XLEN+4:0] exp_a_q[$];
  logic [XLEN+4:0] exp_b_q[$];
  bit              src_log[$];
  bit              log_en = 1'b0;
  int              n_vec = 0;
  int              n_err = 0;

  typedef struct {
    bit              src;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    bit              exp_wr;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [XLEN+4:0] got;
    logic [XLEN+4:0] want;
    bit              from_b;
    if (rst === 1'b0 && Reg_Wr === 1'b1) begin
      got = {Rd_Wr, Rd_In};
      if (exp_a_q.size() == 0 && exp_b_q.size() == 0) begin
        chk("wr_unexpected", got, '0);
      end else begin
        from_b = !(exp_a_q.size() != 0 && exp_a_q[0] == got) && exp_b_q.size() != 0;
        if (from_b) want = exp_b_q.pop_front();
        else        want = exp_a_q.pop_front();
        chk(from_b ? "wr_b" : "wr_a", got, want);
        if (log_en) src_log.push_back(from_b);
      end
    end
  end

  // One clock: check ready/idle against the scoreboard, record handshakes at the edge.
  task automatic step();
    bit a_hs, b_hs;
    @(negedge CLK);
    #1;
    chk("a_ready", A_Ready, !Flush && exp_a_q.size() < DEPTH);
    chk("b_ready", B_Ready, !Flush && exp_b_q.size() < DEPTH);
    chk("idle", Idle, exp_a_q.size() == 0 && exp_b_q.size() == 0 && !Reg_Wr);
    a_hs = A_Valid && A_Ready;
    b_hs = B_Valid && B_Ready;
    @(posedge CLK);
    if (a_hs && A_Rd != 5'd0) exp_a_q.push_back({A_Rd, A_Data});
    if (b_hs && B_Rd != 5'd0) exp_b_q.push_back({B_Rd, B_Data});
    if (Flush) begin
      exp_a_q.delete();
      exp_b_q.delete();
    end
    #1;
  endtask

  task automatic idle_inputs();
    A_Valid = 1'b0; B_Valid = 1'b0; Flush = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 64 && (exp_a_q.size() != 0 || exp_b_q.size() != 0 || Reg_Wr); i++) step();
    chk("drain_a", exp_a_q.size(), 0);
    chk("drain_b", exp_b_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, alt_bad;
    bit a_drop, b_drop;
    tbl[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd5,  32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd31, 32'h12345678, 1'b1, 5'd31, 32'h12345678};
    tbl[3] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd31, 32'h12345678};
    tbl[4] = '{1'b0, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
    tbl[5] = '{1'b1, 5'd16, 32'hA5A5A5A5, 1'b1, 5'd16, 32'hA5A5A5A5};

    rst = 1'b1; idle_inputs();
    A_Rd = '0; B_Rd = '0; A_Data = '0; B_Data = '0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    chk("rst_reg_wr", Reg_Wr, 0);
    chk("rst_rd_wr", Rd_Wr, 0);
    chk("rst_rd_in", Rd_In, 0);
    chk("rst_a_ready", A_Ready, 1);
    chk("rst_b_ready", B_Ready, 1);
    chk("rst_idle", Idle, 1);

    foreach (tbl[i]) begin
      if (tbl[i].src) begin B_Valid = 1'b1; B_Rd = tbl[i].rd; B_Data = tbl[i].data; end
      else            begin A_Valid = 1'b1; A_Rd = tbl[i].rd; A_Data = tbl[i].data; end
      step();
      idle_inputs();
      step();
      chk("vec_reg_wr", Reg_Wr, tbl[i].exp_wr);
      chk("vec_rd_wr", Rd_Wr, tbl[i].exp_rd);
      chk("vec_rd_in", Rd_In, tbl[i].exp_data);
      step();
      chk("vec_wr_done", Reg_Wr, 0);
      chk("vec_idle", Idle, 1);
    end

    // Both sources streaming: alternating grants, both FIFOs fill, nothing lost.
    src_log.delete(); log_en = 1'b1; a_drop = 1'b0; b_drop = 1'b0;
    A_Rd = 5'd1; B_Rd = 5'd2;
    for (int i = 0; i < 20; i++) begin
      A_Valid = 1'b1; A_Data = 32'h11000000 + i;
      B_Valid = 1'b1; B_Data = 32'h22000000 + i;
      if (!A_Ready) a_drop = 1'b1;
      if (!B_Ready) b_drop = 1'b1;
      step();
    end
    drain();
    log_en = 1'b0;
    na = 0; nb = 0; alt_bad = 0;
    foreach (src_log[i]) if (src_log[i]) nb++; else na++;
    for (int i = 1; i < 2 * ((na < nb) ? na : nb); i++)
      if (src_log[i] == src_log[i-1]) alt_bad++;
    chk("a_ready_dropped", a_drop, 1);
    chk("b_ready_dropped", b_drop, 1);
    chk("alternation", alt_bad, 0);
    chk("stream_writes", na + nb >= 20, 1);

    // Flush with entries pending; the input presented during Flush is dropped.
    A_Rd = 5'd3; B_Rd = 5'd4;
    for (int i = 0; i < 6; i++) begin
      A_Valid = 1'b1; A_Data = 32'h33000000 + i;
      B_Valid = 1'b1; B_Data = 32'h44000000 + i;
      step();
    end
    B_Valid = 1'b0; A_Data = 32'h00000BAD; Flush = 1'b1;
    step();
    idle_inputs();
    chk("flush_reg_wr", Reg_Wr, 0);
    chk("flush_idle", Idle, 1);
    repeat (4) step();
    chk("post_flush_reg_wr", Reg_Wr, 0);

`ifdef RF_SCBD_EN
    chk("busy_idle", Busy_Vec, 32'h0);
    A_Valid = 1'b1; A_Rd = 5'd7; A_Data = 32'h77777777;
    step();
    idle_inputs();
    chk("busy_pending", Busy_Vec, 32'h80);
    step();
    chk("busy_writing", Busy_Vec, 32'h80);
    step();
    chk("busy_clear", Busy_Vec, 32'h0);
`endif

    // Random traffic with occasional Flush.
    for (int i = 0; i < 300; i++) begin
      A_Valid = 1'($urandom_range(0, 1));
      A_Rd    = 5'($urandom_range(0, 31));
      A_Data  = $urandom;
      B_Valid = 1'($urandom_range(0, 1));
      B_Rd    = 5'($urandom_range(0, 31));
      B_Data  = $urandom;
      Flush   = ($urandom_range(0, 15) == 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
